// File: rtl/hs4_pkg.sv
// Shared definitions for the hs4 buffered four-phase transmitter.
package hs4_pkg;

  // FSM state codes as seen on the estado port
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    REL   = 3'd2,
    ERR   = 3'd3,
    RETRY = 3'd4
  } state_t;

  // Occupancy counter width: must represent 0..DEPTH inclusive
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs4_fifo.sv
// Small synchronous FIFO; head word is visible combinationally on dout.
module hs4_fifo
  import hs4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W-1:0]           dout,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     count_r;
  logic [LW-1:0]     count_n;
  logic              full_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Writes while full are dropped; pops on an empty FIFO are ignored
  assign do_push_s = push && !full_r;
  assign do_pop_s  = pop && (count_r != {LW{1'b0}});

  // Next occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    count_n = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_n = count_r + {{(LW-1){1'b0}}, 1'b1};
      2'b01:   count_n = count_r - {{(LW-1){1'b0}}, 1'b1};
      default: count_n = count_r;
    endcase
  end

  // Pointers, occupancy and registered full flag; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_n;
      full_r  <= (count_n == LW'(DEPTH));
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign empty = (count_r == {LW{1'b0}});
  assign level = count_r;
  assign full  = full_r;

endmodule

// File: rtl/hs4_tx_buffered.sv
// Buffered four-phase send/ack transmitter with pattern generator,
// per-phase ack timeout, sticky error with retry and a transfer counter.
module hs4_tx_buffered
  import hs4_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15,
  parameter int SEED    = 7,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        full,
  output logic [level_w(DEPTH)-1:0]   level,
  input  logic                        gen_en,
  input  logic                        clr_err,
  output logic [DATA_W-1:0]           dados,
  output logic                        send,
  input  logic                        ack,
  output logic [2:0]                  estado,
  output logic                        timeout_err,
  output logic [CNT_W-1:0]            sent_cnt
);

  localparam int               TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] SEED_V = DATA_W'(SEED);

  state_t            state_r, state_n;
  logic [DATA_W-1:0] dados_r, dados_n;
  logic              send_r, send_n;
  logic              err_r, err_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [DATA_W-1:0] gen_r, gen_n;
  logic              src_fifo_r, src_fifo_n;
  logic [TW-1:0]     tcnt_r, tcnt_n;
  logic              pop_s;
  logic              empty_s;
  logic [DATA_W-1:0] head_s;

  hs4_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop_s),
    .din   (wr_data),
    .dout  (head_s),
    .full  (full),
    .empty (empty_s),
    .level (level)
  );

  // Next-state, output and bookkeeping decisions of the handshake FSM
  always_comb begin
    state_n    = state_r;
    dados_n    = dados_r;
    send_n     = send_r;
    err_n      = err_r;
    cnt_n      = cnt_r;
    gen_n      = gen_r;
    src_fifo_n = src_fifo_r;
    tcnt_n     = {TW{1'b0}};
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // FIFO content takes precedence over the generator
        if (!empty_s) begin
          dados_n    = head_s;
          src_fifo_n = 1'b1;
          send_n     = 1'b1;
          state_n    = REQ;
        end else if (gen_en) begin
          dados_n    = gen_r;
          src_fifo_n = 1'b0;
          send_n     = 1'b1;
          state_n    = REQ;
        end else begin
          send_n = 1'b0;
        end
      end
      REQ: begin
        // ack is checked first so it wins over a simultaneous expiry
        if (ack) begin
          send_n  = 1'b0;
          state_n = REL;
        end else if (tcnt_r == T_LAST) begin
          send_n  = 1'b0;
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          send_n = 1'b1;
          tcnt_n = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      REL: begin
        send_n = 1'b0;
        if (!ack) begin
          pop_s = src_fifo_r;
          if (src_fifo_r) begin
            gen_n = gen_r;
          end else begin
            gen_n = gen_r + {{(DATA_W-1){1'b0}}, 1'b1};
          end
          cnt_n   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          state_n = IDLE;
        end else if (tcnt_r == T_LAST) begin
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          tcnt_n = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      ERR: begin
        // Word and source are kept so the retry resends the same data
        send_n = 1'b0;
        if (clr_err) begin
          err_n   = 1'b0;
          state_n = RETRY;
        end else begin
          err_n = 1'b1;
        end
      end
      RETRY: begin
        // Peripheral must have released ack before a new request
        if (!ack) begin
          send_n  = 1'b1;
          state_n = REQ;
        end else begin
          send_n = 1'b0;
        end
      end
      default: begin
        send_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      dados_r    <= {DATA_W{1'b0}};
      send_r     <= 1'b0;
      err_r      <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      gen_r      <= SEED_V;
      src_fifo_r <= 1'b0;
      tcnt_r     <= {TW{1'b0}};
    end else begin
      state_r    <= state_n;
      dados_r    <= dados_n;
      send_r     <= send_n;
      err_r      <= err_n;
      cnt_r      <= cnt_n;
      gen_r      <= gen_n;
      src_fifo_r <= src_fifo_n;
      tcnt_r     <= tcnt_n;
    end
  end

  assign estado      = state_r;
  assign dados       = dados_r;
  assign send        = send_r;
  assign timeout_err = err_r;
  assign sent_cnt    = cnt_r;

endmodule

// File: doc/hs4_tx_buffered.md
Name: hs4_tx_buffered

Overview:
- Parametrised four-phase send/ack transmitter: the next generation of the CPU-side handshake sender.
- Words enter through a small synchronous FIFO. When the FIFO is empty and gen_en=1, an internal incrementing pattern generator supplies the words instead.
- Adds a per-phase ack timeout with a sticky error, retry of the in-flight word, and a transfer counter.
- Sits between a host write port and a peripheral that answers with ack on the same clock.

Parameters:
- DATA_W, 4, width of the data word.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2.
- TIMEOUT, 15, maximum cycles to wait in either ack phase before flagging an error; must be at least 1.
- SEED, 7, generator start value, truncated to DATA_W.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  host write strobe.
- wr_data  in  DATA_W  host word.
- full  out  1  FIFO full.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- gen_en  in  1  enables the generator when the FIFO is empty.
- clr_err  in  1  clears timeout_err and triggers a retry.
- dados  out  DATA_W  word presented to the peripheral.
- send  out  1  request line.
- ack  in  1  peripheral acknowledge, same clock domain, sampled without a synchronizer.
- estado  out  3  current FSM state code.
- timeout_err  out  1  sticky timeout flag.
- sent_cnt  out  CNT_W  completed-transfer count, wraps.

Behaviour:
- All outputs are registered.
- Reset values while rst=0 at a clock edge:
  - send=0, dados=0, estado=IDLE, timeout_err=0, sent_cnt=0.
  - FIFO emptied: level=0, full=0.
  - Generator value set to SEED.
- Reset mid-transfer aborts the transfer; the in-flight word is lost.
- FIFO:
  - A write is accepted iff wr_en=1 and full=0. A write while full is dropped silently.
  - A pop happens only on transfer completion.
  - A write and a pop in the same cycle: level is unchanged.
  - Pointers wrap modulo DEPTH.
- Source priority: FIFO non-empty beats the generator. The generator is used only when level=0 and gen_en=1.
- FSM states (estado code):
  - IDLE (0): send=0. If a source is available, at the next edge load dados from the source and set send=1, then go to REQ. Latency from a write into an empty FIFO to send=1 is 1 cycle after the write edge.
  - REQ (1): send=1 and dados held stable. On ack=1, go to REL and set send=0. If TIMEOUT cycles pass with ack=0, go to ERR.
  - REL (2): send=0. On ack=0, complete the transfer and go to IDLE.
    - Completion: pop the FIFO if the word came from it, otherwise increment the generator modulo 2^DATA_W.
    - sent_cnt increments on completion.
    - If TIMEOUT cycles pass with ack=1, go to ERR.
  - ERR (3): send=0, timeout_err=1. dados and the source selection are retained; nothing is popped and the generator is not advanced.
    - clr_err=1 clears timeout_err at the next edge and moves to RETRY.
  - RETRY (4): wait until ack=0, then set send=1 with the retained dados and go to REQ.
- Timeout counter:
  - Reset on every state change.
  - Counts cycles in REQ and REL only.
  - An error fires when the count reaches TIMEOUT with the awaited condition still absent.
- If ack and the timeout expiry occur in the same cycle, ack wins.
- gen_en falling during REQ or REL does not abort the transfer; it only affects source selection in IDLE.
- Unused state codes 5–7 return to IDLE with send=0.

Decomposition:
- Package hs4_pkg:
  - State localparams IDLE/REQ/REL/ERR/RETRY with their 3-bit codes.
  - Function for the level width ($clog2(DEPTH)+1).
- One sub-module hs4_fifo (parameters DATA_W, DEPTH):
  - Ports: push, pop, din, dout, full, empty, level.
  - dout shows the head word combinationally.
- Top level holds the FSM, timeout counter, generator and sent_cnt.

Test Plan:
- Reset with the FIFO empty and gen_en=0; no stimulus for 20 cycles -> send=0, estado=0, sent_cnt=0 throughout.
- Write 0x3; the peripheral model raises ack 2 cycles after send and drops it 2 cycles after send falls -> send=1 with dados=3 one cycle after the write; one full handshake; then sent_cnt=1, level=0, estado=0.
- gen_en=1 with the FIFO empty, defaults, responsive peripheral -> dados sequence 7,8,...,F,0,1 (wrap at 4 bits); sent_cnt counts each word.
- gen_en=1 and a host write of 0xA while the generator's word 7 is in flight -> 7 completes first, then A, then the generator resumes at 8.
- Fill 4 words, then a fifth write with the peripheral stalled (ack held 0) -> full=1, fifth word dropped, level=4.
  - After 15 cycles in REQ: timeout_err=1, estado=3, send=0.
  - clr_err with ack=0 -> RETRY, then REQ with the same dados.
  - All 4 words are delivered in order.
- Assert rst=0 while in REL -> at the next edge send=0, level=0, estado=0, timeout_err=0, sent_cnt=0.
